// File: rtl/button_event_detector_multi.sv
// rtl/button_event_detector_multi.sv - multi-channel debounced button edge detector with event counter
//
// Purpose: each channel synchronises a raw button level, debounces it with a
// four-state FSM and emits a one-cycle event pulse on accepted rising and/or
// falling transitions. The transitions that produce events are selected by the
// shared mode qualifier. A saturating counter totals the qualified events
// across all channels.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   y[N]         raw asynchronous button levels
//   mode[2]      event qualifier: 00 none, 01 rising, 10 falling, 11 both
//   clr_cnt      synchronous clear of event_count; wins over same-cycle events
//   e[N]         registered one-cycle event pulse per channel
//   level[N]     registered debounced level per channel
//   event_count  saturating total of qualified events

module button_event_detector_multi #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     y,
    input  logic [1:0]       mode,
    input  logic             clr_cnt,
    output logic [N-1:0]     e,
    output logic [N-1:0]     level,
    output logic [CNT_W-1:0] event_count
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // Sum width leaves room for up to 32 events on top of a full counter.
    localparam int SW = CNT_W + 6;
    localparam logic [SW-1:0] CNT_SAT = SW'((64'd1 << CNT_W) - 64'd1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    logic [N-1:0]     s1;
    logic [N-1:0]     y_s;
    state_t           state     [N];
    state_t           state_nxt [N];
    logic [CW-1:0]    cnt       [N];
    logic [CW-1:0]    cnt_nxt   [N];
    logic [N-1:0]     rise;
    logic [N-1:0]     fall;
    logic [N-1:0]     e_nxt;
    logic [N-1:0]     level_nxt;
    logic [SW-1:0]    total;
    logic [CNT_W-1:0] count_nxt;

    // State register: synchroniser, FSMs, debounce counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            y_s         <= '0;
            e           <= '0;
            level       <= '0;
            event_count <= '0;
            for (int i = 0; i < N; i++) begin
                state[i] <= LOW;
                cnt[i]   <= '0;
            end
        end else begin
            s1          <= y;
            y_s         <= s1;
            e           <= e_nxt;
            level       <= level_nxt;
            event_count <= count_nxt;
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Next-state logic: independent of mode so the debounce never depends on
    // which transitions are being reported.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = '0;
            case (state[i])
                LOW: begin
                    if (y_s[i]) begin
                        if (DB_CYCLES == 1) begin
                            state_nxt[i] = HIGH;
                        end else begin
                            state_nxt[i] = RISE_CHK;
                            cnt_nxt[i]   = CNT_ONE;
                        end
                    end
                end
                RISE_CHK: begin
                    if (!y_s[i]) begin
                        state_nxt[i] = LOW;
                    end else if (cnt[i] + CNT_ONE == DB_MAX) begin
                        state_nxt[i] = HIGH;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!y_s[i]) begin
                        if (DB_CYCLES == 1) begin
                            state_nxt[i] = LOW;
                        end else begin
                            state_nxt[i] = FALL_CHK;
                            cnt_nxt[i]   = CNT_ONE;
                        end
                    end
                end
                FALL_CHK: begin
                    if (y_s[i]) begin
                        state_nxt[i] = HIGH;
                    end else if (cnt[i] + CNT_ONE == DB_MAX) begin
                        state_nxt[i] = LOW;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt[i] = LOW;
                end
            endcase
        end
    end

    // Output logic: a rise is entry into HIGH from the low side only, so an
    // aborted fall check (FALL_CHK -> HIGH) is not reported, and vice versa.
    always_comb begin
        rise      = '0;
        fall      = '0;
        e_nxt     = '0;
        level_nxt = level;
        total     = SW'(event_count);
        for (int i = 0; i < N; i++) begin
            rise[i] = (state_nxt[i] == HIGH) && ((state[i] == LOW) || (state[i] == RISE_CHK));
            fall[i] = (state_nxt[i] == LOW) && ((state[i] == HIGH) || (state[i] == FALL_CHK));
            e_nxt[i] = (rise[i] && mode[0]) || (fall[i] && mode[1]);
            if (rise[i]) begin
                level_nxt[i] = 1'b1;
            end else if (fall[i]) begin
                level_nxt[i] = 1'b0;
            end
            total = total + SW'(e_nxt[i]);
        end
        if (clr_cnt) begin
            count_nxt = '0;
        end else if (total > CNT_SAT) begin
            count_nxt = CNT_SAT[CNT_W-1:0];
        end else begin
            count_nxt = total[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_button_event_detector_multi.sv
// tb/tb_button_event_detector_multi.sv - directed self-checking bench for button_event_detector_multi

module tb_button_event_detector_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] y;
    logic [1:0] mode;
    logic       clr_cnt;
    logic [3:0] e;
    logic [3:0] level;
    logic [7:0] event_count;

    logic [0:0] y_b;
    logic [1:0] mode_b;
    logic       clr_b;
    logic [0:0] e_b;
    logic [0:0] level_b;
    logic [1:0] count_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_event_detector_multi #(.N(4), .DB_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .y           (y),
        .mode        (mode),
        .clr_cnt     (clr_cnt),
        .e           (e),
        .level       (level),
        .event_count (event_count)
    );

    button_event_detector_multi #(.N(1), .DB_CYCLES(1), .CNT_W(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .y           (y_b),
        .mode        (mode_b),
        .clr_cnt     (clr_b),
        .e           (e_b),
        .level       (level_b),
        .event_count (count_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   pulses;
        logic seen;

        rst     = 1'b1;
        y       = 4'b0000;
        mode    = 2'b01;
        clr_cnt = 1'b0;
        y_b     = 1'b0;
        mode_b  = 2'b11;
        clr_b   = 1'b0;
        tick(3);
        check("reset_e", 32'(e), 32'h0);
        check("reset_level", 32'(level), 32'h0);
        check("reset_count", 32'(event_count), 32'h0);
        check("reset_b_count", 32'(count_b), 32'h0);
        rst = 1'b0;

        // Clean rise on channel 0: captured at edge 0, pulse at edge 5.
        y = 4'b0001;
        tick(1);
        tick(4);
        check("rise0_edge4_e", 32'(e), 32'h0);
        check("rise0_edge4_level", 32'(level), 32'h0);
        tick(1);
        check("rise0_edge5_e", 32'(e), 32'h1);
        check("rise0_edge5_level", 32'(level), 32'h1);
        check("rise0_edge5_count", 32'(event_count), 32'h1);
        tick(1);
        check("rise0_edge6_e", 32'(e), 32'h0);
        check("rise0_edge6_level", 32'(level), 32'h1);

        // Three-cycle glitch on channel 1 must be rejected.
        y = 4'b0011;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen = seen | e[1];
        end
        y = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | e[1];
        end
        check("glitch1_no_event", 32'(seen), 32'h0);
        check("glitch1_level", 32'(level), 32'h1);
        check("glitch1_count", 32'(event_count), 32'h1);

        // Press and release on channel 2 with both edges enabled.
        mode = 2'b11;
        pulses = 0;
        y = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (e[2]) pulses++;
        end
        y = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (e[2]) pulses++;
        end
        check("both_pulses", 32'(pulses), 32'd2);
        check("both_count", 32'(event_count), 32'd3);

        // Same press and release with only falling edges enabled.
        mode = 2'b10;
        pulses = 0;
        y = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (e[2]) pulses++;
        end
        y = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (e[2]) pulses++;
        end
        check("fall_pulses", 32'(pulses), 32'd1);
        check("fall_count", 32'(event_count), 32'd4);
        check("fall_level", 32'(level), 32'h1);

        // Drop channel 0 silently, then rise all four together.
        mode = 2'b00;
        y = 4'b0000;
        tick(12);
        check("quiet_fall_level", 32'(level), 32'h0);
        check("quiet_fall_count", 32'(event_count), 32'd4);
        mode = 2'b01;
        y = 4'b1111;
        tick(6);
        check("all_rise_e", 32'(e), 32'hf);
        check("all_rise_level", 32'(level), 32'hf);
        check("all_rise_count", 32'(event_count), 32'd8);
        tick(1);
        check("all_rise_after_e", 32'(e), 32'h0);

        // Repeat the simultaneous rise with clr_cnt on the event edge.
        mode = 2'b00;
        y = 4'b0000;
        tick(12);
        check("quiet_all_count", 32'(event_count), 32'd8);
        mode = 2'b01;
        y = 4'b1111;
        tick(5);
        clr_cnt = 1'b1;
        tick(1);
        check("clr_e", 32'(e), 32'hf);
        check("clr_count", 32'(event_count), 32'd0);
        clr_cnt = 1'b0;
        tick(1);
        check("clr_after_count", 32'(event_count), 32'd0);
        check("clr_after_e", 32'(e), 32'h0);

        // Reset in the middle of a rise check on channel 3.
        mode = 2'b00;
        y = 4'b0000;
        tick(12);
        mode = 2'b01;
        y = 4'b1000;
        tick(3);
        rst = 1'b1;
        tick(1);
        check("midrst_e", 32'(e), 32'h0);
        check("midrst_level", 32'(level), 32'h0);
        check("midrst_count", 32'(event_count), 32'h0);
        rst = 1'b0;
        tick(5);
        check("midrst_early_e", 32'(e), 32'h0);
        check("midrst_early_level", 32'(level), 32'h0);
        tick(1);
        check("midrst_rise_e", 32'(e), 32'h8);
        check("midrst_rise_level", 32'(level), 32'h8);
        check("midrst_rise_count", 32'(event_count), 32'h1);

        // Single-sample debounce and 2-bit saturating counter.
        y_b = 1'b1;
        tick(2);
        check("db1_edge1_e", 32'(e_b), 32'h0);
        tick(1);
        check("db1_edge2_e", 32'(e_b), 32'h1);
        check("db1_edge2_level", 32'(level_b), 32'h1);
        check("db1_edge2_count", 32'(count_b), 32'd1);
        y_b = 1'b0;
        tick(4);
        check("sat_2_events", 32'(count_b), 32'd2);
        y_b = 1'b1;
        tick(4);
        check("sat_3_events", 32'(count_b), 32'd3);
        y_b = 1'b0;
        tick(4);
        check("sat_4_events", 32'(count_b), 32'd3);
        y_b = 1'b1;
        tick(4);
        check("sat_5_events", 32'(count_b), 32'd3);
        check("sat_5_level", 32'(level_b), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
